vdac_sar: RTL and testbench
===========================

# vdac_sar

Successive-approximation controller that closes the loop around the `vdac` voltage DAC in the temperature sensor. It drives the DAC code and enable, samples an external comparator (analog input vs. `vout_notouch_`), and resolves one bit per step MSB-first. It produces a `BITWIDTH`-bit conversion result with a done pulse. It sits between the sensor front-end comparator and the register interface that reads temperature codes.

## Interface
Parameters:
- `BITWIDTH`, default 6. Conversion width; must match the attached `vdac`.
- `SETTLE_CYCLES`, default 2. Cycles a trial code is held before the comparator is sampled. Minimum 1; 0 is illegal.

Ports:
- `i_clk`, input, 1. Single clock.
- `i_reset`, input, 1. Synchronous, active-high reset.
- `i_start`, input, 1. Conversion request. Level-sampled only in IDLE.
- `i_comp`, input, 1. Comparator output: 1 means analog input ≥ DAC output.
- `o_dac_data`, output, `BITWIDTH`. Trial code to `vdac.i_data`.
- `o_dac_enable`, output, 1. Drives `vdac.i_enable`.
- `o_result`, output, `BITWIDTH`. Last completed conversion; held until the next DONE.
- `o_done`, output, 1. One-cycle pulse when `o_result` updates.
- `o_busy`, output, 1. High from the cycle after start acceptance through DONE.

## Operation
- States: IDLE, SETTLE, DECIDE, DONE.
- **IDLE**
  - `o_dac_enable`=0, `o_dac_data`=0, `o_busy`=0.
  - If `i_start`=1: load trial code with only bit `BITWIDTH-1` set, bit index = `BITWIDTH-1`, settle counter = 0; go to SETTLE.
- **SETTLE**
  - `o_dac_enable`=1; trial code stable on `o_dac_data`.
  - Counter increments each cycle. After `SETTLE_CYCLES` cycles, go to DECIDE.
- **DECIDE** (one cycle)
  - Sample the comparator. If 0, clear the current bit; if 1, keep it.
  - If bit index > 0: set the next lower bit, decrement the index, clear the counter, go to SETTLE.
  - Otherwise: copy the final code to `o_result` and go to DONE.
- **DONE** (one cycle)
  - `o_done`=1, `o_busy`=1, `o_dac_enable`=1. Go to IDLE.
- Code arithmetic is plain unsigned binary on `BITWIDTH` bits; there is no wrap or overflow. Sign/segment decoding is handled inside `vdac`.
- `i_start` asserted while busy is ignored; no request is queued.
- `i_start` held high continuously gives back-to-back conversions, with one IDLE cycle between DONE and the next SETTLE.
- `i_reset` at any time, including mid-conversion, takes effect at the next edge: state→IDLE, all counters cleared, all outputs to reset values. A partial conversion is discarded.
- Reset values: `o_dac_data`=0, `o_dac_enable`=0, `o_result`=0, `o_done`=0, `o_busy`=0.

## Timing
- All outputs are registered.
- Start edge at cycle 0 (IDLE, `i_start`=1).
  - First trial code and `o_busy`=1 appear at cycle 1.
- Each bit takes `SETTLE_CYCLES`+1 cycles. `o_done`=1 at cycle `BITWIDTH`*(`SETTLE_CYCLES`+1)+1; defaults give cycle 19.
- The comparator value used for a bit is `i_comp` at the DECIDE-cycle edge, `SETTLE_CYCLES` cycles after the trial code changed.
- `o_dac_data` changes only on SETTLE entry, never during SETTLE.

## Configuration
- Macro `VDAC_SAR_COMP_SYNC_EN`.
- **Defined**
  - `i_comp` passes through a 2-flop synchronizer (reset to 0); DECIDE uses the synchronizer output.
  - The effective hold per bit becomes `SETTLE_CYCLES`+2 cycles: SETTLE lasts `SETTLE_CYCLES`+2 cycles.
  - Latency = `BITWIDTH`*(`SETTLE_CYCLES`+3)+1; defaults give 31.
- **Undefined**
  - `i_comp` is sampled directly. The source must be synchronous to `i_clk`.
  - Latency as in Timing.

## Test plan
All scenarios use defaults, macro undefined. The bench models the comparator as `i_comp` = (target ≥ `o_dac_data`) combinationally.
- Target 37, pulse `i_start` at cycle 0 → trial codes 32, 48, 40, 36, 38, 37; `o_done` at cycle 19; `o_result`=37; `o_busy` low at cycle 20.
- Targets 0 and 63 → `o_result`=0 and 63 respectively, each with `o_done` at cycle 19.
- Target 20; pulse `i_start` again at cycles 5 and 18 → single `o_done` at 19, `o_result`=20, no second conversion.
- Target 37; assert `i_reset` for one cycle at cycle 10 → cycle 11: all outputs zero, state IDLE; a fresh start yields 37 nineteen cycles later.
- Hold `i_start`=1, target 37 then 12 (change between conversions) → `o_done` at cycles 19 and 39, results 37 then 12.
- With `VDAC_SAR_COMP_SYNC_EN` defined, target 37 → `o_done` at cycle 31, `o_result`=37.

Source files
------------

// File: rtl/vdac_sar.sv
// Successive-approximation controller for vdac: drives trial codes MSB-first and resolves one bit per step.
// Optional macro VDAC_SAR_COMP_SYNC_EN adds a 2-flop comparator synchronizer and stretches SETTLE by 2 cycles.
module vdac_sar #(
  parameter int BITWIDTH      = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_comp,
  output logic [BITWIDTH-1:0] o_dac_data,
  output logic                o_dac_enable,
  output logic [BITWIDTH-1:0] o_result,
  output logic                o_done,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DECIDE,
    S_DONE
  } state_t;

  localparam logic [BITWIDTH-1:0] MSB = BITWIDTH'(1) << (BITWIDTH - 1);

  logic comp;

`ifdef VDAC_SAR_COMP_SYNC_EN
  localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
  logic [1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_comp};
    end
  end

  assign comp = sync_q[1];
`else
  localparam int SETTLE_LEN = SETTLE_CYCLES;
  assign comp = i_comp;
`endif

  localparam int CNT_W = (SETTLE_LEN < 2) ? 1 : $clog2(SETTLE_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_LEN - 1);

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] code_q, code_d;
  logic [BITWIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BITWIDTH-1:0] result_q, result_d;
  logic [BITWIDTH-1:0] dac_q, dac_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BITWIDTH-1:0] decided;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    decided  = comp ? code_q : (code_q & ~mask_q);

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          code_d  = MSB;
          mask_d  = MSB;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DECIDE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECIDE: begin
        // mask_q is the one-hot of the bit being resolved; bit 0 ends the conversion
        if (mask_q[0]) begin
          code_d   = decided;
          result_d = decided;
          state_d  = S_DONE;
        end else begin
          mask_d  = mask_q >> 1;
          code_d  = decided | (mask_q >> 1);
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // DAC code only moves on SETTLE entry; DONE keeps the last trial code driven
    if (state_d == S_IDLE) begin
      dac_d = '0;
    end else if (state_d == S_SETTLE) begin
      dac_d = code_d;
    end else begin
      dac_d = dac_q;
    end
    en_d   = (state_d != S_IDLE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dac_q    <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dac_q    <= dac_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_dac_data   = dac_q;
  assign o_dac_enable = en_q;
  assign o_result     = result_q;
  assign o_done       = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_vdac_sar.sv
// Scoreboard bench for vdac_sar: comparator modelled as (target >= DAC code); expected trial codes
// and done events are queued at stimulus time and consumed by a negedge monitor.
module tb_vdac_sar;
  localparam int BW = 6;
`ifdef VDAC_SAR_COMP_SYNC_EN
  localparam int LAT = 31;
`else
  localparam int LAT = 19;
`endif
  localparam int PER_BIT = (LAT - 1) / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          comp;
  logic [BW-1:0] target;
  logic [BW-1:0] dac_data;
  logic          dac_en;
  logic [BW-1:0] result;
  logic          done;
  logic          busy;

  always #5 clk = ~clk;

  vdac_sar #(.BITWIDTH(BW), .SETTLE_CYCLES(2)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_comp      (comp),
    .o_dac_data  (dac_data),
    .o_dac_enable(dac_en),
    .o_result    (result),
    .o_done      (done),
    .o_busy      (busy)
  );

  assign comp = (target >= dac_data);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] res;
    int            at;
  } exp_t;

  exp_t          done_q[$];
  logic [BW-1:0] trial_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expected done events and trial codes as the DUT presents them.
  logic          prev_en = 1'b0;
  logic [BW-1:0] prev_dac = '0;
  always @(negedge clk) begin
    exp_t          e;
    logic [BW-1:0] t;
    if (done) begin
      if (done_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done at cycle %0d: result %0d, no conversion expected", cyc, result);
      end else begin
        e = done_q.pop_front();
        check("done_cycle", cyc, e.at);
        check("result", result, e.res);
      end
    end
    if (dac_en && (!prev_en || dac_data != prev_dac)) begin
      if (trial_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_trial at cycle %0d: code %0d, none expected", cyc, dac_data);
      end else begin
        t = trial_q.pop_front();
        check("trial_code", dac_data, t);
      end
    end
    prev_en  = dac_en;
    prev_dac = dac_data;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge: raises start, queues the first ntr trial codes and optionally the done event.
  task automatic launch(input logic [BW-1:0] tgt, input logic [6*BW-1:0] tr, input int ntr,
                        input bit exp_done, output int t0);
    target = tgt;
    t0     = cyc;
    start  = 1'b1;
    for (int i = 0; i < ntr; i++) trial_q.push_back(tr[6*BW-1-BW*i -: BW]);
    if (exp_done) done_q.push_back('{res: tgt, at: t0 + LAT});
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pending_done"}, done_q.size(), 0);
    check({tag, "_pending_trials"}, trial_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dac_data"}, dac_data, 0);
    check({tag, "_dac_enable"}, dac_en, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  localparam logic [6*BW-1:0] TR37 = {6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37};
  localparam logic [6*BW-1:0] TR12 = {6'd32, 6'd16, 6'd8, 6'd12, 6'd14, 6'd13};
  localparam logic [6*BW-1:0] TR20 = {6'd32, 6'd16, 6'd24, 6'd20, 6'd22, 6'd21};
  localparam logic [6*BW-1:0] TR00 = {6'd32, 6'd16, 6'd8, 6'd4, 6'd2, 6'd1};
  localparam logic [6*BW-1:0] TR63 = {6'd32, 6'd48, 6'd56, 6'd60, 6'd62, 6'd63};

  initial begin
    int t0;
    rst    = 1'b1;
    start  = 1'b0;
    target = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Target 37, single start pulse
    launch(6'd37, TR37, 6, 1'b1, t0);
    @(negedge clk);
    start = 1'b0;
    check("first_busy", busy, 1);
    check("first_trial", dac_data, 32);
    wait_until(t0 + LAT + 1);
    check("busy_after_done", busy, 0);
    check("enable_after_done", dac_en, 0);
    check("result_held", result, 37);
    repeat (4) @(negedge clk);
    check_drained("t37");

    // Extremes
    launch(6'd0, TR00, 6, 1'b1, t0);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + LAT + 4);
    check_drained("t0");
    launch(6'd63, TR63, 6, 1'b1, t0);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + LAT + 4);
    check_drained("t63");

    // Starts while busy are ignored
    launch(6'd20, TR20, 6, 1'b1, t0);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 18);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + LAT + 1);
    check("busy_low_after_t20", busy, 0);
    @(negedge clk);
    check("no_queued_start", busy, 0);
    repeat (LAT + 3) @(negedge clk);
    check_drained("t20");

    // Mid-conversion reset discards the partial result
    launch(6'd37, TR37, (10 - 1) / PER_BIT + 1, 1'b0, t0);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("midreset");
    check_drained("midreset");
    launch(6'd37, TR37, 6, 1'b1, t0);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + LAT + 4);
    check_drained("after_reset");

    // Start held high: back-to-back, target changed between conversions
    launch(6'd37, TR37, 6, 1'b1, t0);
    for (int i = 0; i < 6; i++) trial_q.push_back(TR12[6*BW-1-BW*i -: BW]);
    done_q.push_back('{res: 6'd12, at: t0 + 2 * LAT + 1});
    wait_until(t0 + LAT + 1);
    target = 6'd12;
    wait_until(t0 + LAT + 2);
    start = 1'b0;
    wait_until(t0 + 2 * LAT + 2);
    check("b2b_result", result, 12);
    repeat (4) @(negedge clk);
    check_drained("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
